// File: rtl/quad_sweep_sched_pkg.sv
// Shared types and reset defaults for the quadrature sweep scheduler.
// Imported by the interface-facing top and its counters.
package quad_sweep_pkg;

  localparam int QS_ADDR_W  = 8;
  localparam int QS_CYC_W   = 16;
  localparam int DEF_PERIOD = 80;
  localparam int DEF_OFFSET = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } qs_state_e;

  typedef struct packed {
    logic [QS_ADDR_W-1:0] period;
    logic [QS_ADDR_W-1:0] offset;
    logic [QS_CYC_W-1:0]  cycles;
  } qs_cfg_t;

  function automatic qs_cfg_t qs_def_cfg();
    qs_cfg_t c;
    c.period = QS_ADDR_W'(DEF_PERIOD);
    c.offset = QS_ADDR_W'(DEF_OFFSET);
    c.cycles = '0;
    return c;
  endfunction

endpackage

// File: rtl/quad_sweep_sched_if.sv
// Host command / address stream bundle of the sweep scheduler.
// master drives configuration and run control, slave is the scheduler.
interface quad_sweep_sched_if #(
  parameter int ADDR_W = 8,
  parameter int CYC_W  = 16
);
  logic              CFG_VALID;
  logic              CFG_READY;
  logic [ADDR_W-1:0] CFG_PERIOD;
  logic [ADDR_W-1:0] CFG_OFFSET;
  logic [CYC_W-1:0]  CFG_CYCLES;
  logic              START;
  logic              ABORT;
  logic [ADDR_W-1:0] SIN_ADDR;
  logic [ADDR_W-1:0] COS_ADDR;
  logic              ADDR_VALID;
  logic              PERIOD_START;
  logic              BUSY;
  logic              DONE;
  logic              CFG_ERR;

  modport master (
    output CFG_VALID, CFG_PERIOD, CFG_OFFSET, CFG_CYCLES,
    output START, ABORT,
    input  CFG_READY, SIN_ADDR, COS_ADDR, ADDR_VALID,
    input  PERIOD_START, BUSY, DONE, CFG_ERR
  );

  modport slave (
    input  CFG_VALID, CFG_PERIOD, CFG_OFFSET, CFG_CYCLES,
    input  START, ABORT,
    output CFG_READY, SIN_ADDR, COS_ADDR, ADDR_VALID,
    output PERIOD_START, BUSY, DONE, CFG_ERR
  );
endinterface

// File: rtl/quad_sweep_sched_wrap_counter.sv
// Loadable modulo counter: counts 0..limit_i while enabled, load wins.
// wrap_o flags the enabled cycle that rolls limit_i back to zero.
module wrap_counter #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] q_o,
  output logic         wrap_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)
      q_d = load_val_i;
    else if (en_i)
      q_d = (q_q == limit_i) ? '0 : q_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= RST_VAL;
    else       q_q <= q_d;
  end

  assign q_o    = q_q;
  assign wrap_o = en_i && (q_q == limit_i);

endmodule

// File: rtl/quad_sweep_sched.sv
// Quadrature SIN/COS address scheduler: whole-period runs under host control.
// QSCHED_IMMEDIATE_ABORT_EN: ABORT in RUN ends the run at the next edge.
module quad_sweep_sched #(
  parameter int ADDR_W     = quad_sweep_pkg::QS_ADDR_W,
  parameter int CYC_W      = quad_sweep_pkg::QS_CYC_W,
  parameter int DEF_PERIOD = quad_sweep_pkg::DEF_PERIOD,
  parameter int DEF_OFFSET = quad_sweep_pkg::DEF_OFFSET
) (
  input logic               CLK,
  input logic               RST,
  quad_sweep_sched_if.slave bus
);
  import quad_sweep_pkg::*;

  qs_state_e         state_q, state_d;
  qs_cfg_t           cfg_q, cfg_in, cfg_eff, cfg_rst;
  logic [CYC_W-1:0]  pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] sin_q, cos_q, limit;
  logic              cfg_hs, cfg_ok, cfg_acc;
  logic              run_en, cnt_load, last_per;
  logic              sin_wrap, cos_wrap_unused;
  logic              done_q, err_q;

  assign cfg_in = '{period: bus.CFG_PERIOD,
                    offset: bus.CFG_OFFSET,
                    cycles: bus.CFG_CYCLES};

  always_comb begin
    cfg_rst        = qs_def_cfg();
    cfg_rst.period = ADDR_W'(DEF_PERIOD);
    cfg_rst.offset = ADDR_W'(DEF_OFFSET);
  end

  assign cfg_hs  = bus.CFG_VALID && (state_q == IDLE);
  assign cfg_ok  = (bus.CFG_PERIOD >= ADDR_W'(2)) &&
                   (bus.CFG_OFFSET < bus.CFG_PERIOD);
  assign cfg_acc = cfg_hs && cfg_ok;
  // a START alongside an accepted offer must see the new config
  assign cfg_eff = cfg_acc ? cfg_in : cfg_q;

  assign run_en   = (state_q != IDLE);
  assign limit    = cfg_q.period - 1'b1;
  assign last_per = (cfg_q.cycles != '0) &&
                    (pcnt_q + 1'b1 == cfg_q.cycles);
  assign cnt_load = (state_q == IDLE) || (state_d == IDLE);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE: begin
        pcnt_d = '0;
        if (bus.START && !bus.ABORT) state_d = RUN;
      end
      RUN: begin
        if (sin_wrap) pcnt_d = pcnt_q + 1'b1;
        if (sin_wrap && last_per)
          state_d = IDLE;
        else if (bus.ABORT)
`ifdef QSCHED_IMMEDIATE_ABORT_EN
          state_d = IDLE;
`else
          state_d = STOP;
`endif
      end
      STOP: begin
        if (sin_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.CFG_READY    = (state_q == IDLE);
    bus.BUSY         = run_en;
    bus.ADDR_VALID   = run_en;
    bus.PERIOD_START = run_en && (sin_q == '0);
    bus.SIN_ADDR     = sin_q;
    bus.COS_ADDR     = cos_q;
    bus.DONE         = done_q;
    bus.CFG_ERR      = err_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_q  <= cfg_rst;
      pcnt_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cfg_q  <= cfg_eff;
      pcnt_q <= pcnt_d;
      done_q <= run_en && (state_d == IDLE);
      err_q  <= cfg_hs && !cfg_ok;
    end
  end

  wrap_counter #(
    .W       (ADDR_W),
    .RST_VAL ('0)
  ) u_sin (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i ('0),
    .en_i       (run_en),
    .limit_i    (limit),
    .q_o        (sin_q),
    .wrap_o     (sin_wrap)
  );

  wrap_counter #(
    .W       (ADDR_W),
    .RST_VAL (ADDR_W'(DEF_OFFSET))
  ) u_cos (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cfg_eff.offset),
    .en_i       (run_en),
    .limit_i    (limit),
    .q_o        (cos_q),
    .wrap_o     (cos_wrap_unused)
  );

endmodule

// File: tb/tb_quad_sweep_sched.sv
// Self-checking bench for quad_sweep_sched: run-position reference model
// compared every cycle, plus directed literal checks and random traffic.
module tb_quad_sweep_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quad_sweep_sched_if #(.ADDR_W(8), .CYC_W(16)) bus();

  quad_sweep_sched #(
    .ADDR_W(8), .CYC_W(16), .DEF_PERIOD(80), .DEF_OFFSET(20)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // model: a run is a position k counted from START
  bit m_init = 0, m_run = 0, m_stop = 0, e_done = 0, e_err = 0;
  int m_k = 0, m_per = 80, m_off = 20, m_cyc = 0;

  task automatic end_run();
    m_run  = 0;
    m_stop = 0;
    e_done = 1;
  endtask

  always @(posedge clk) begin
    bit last;
    e_done = 0;
    e_err  = 0;
    if (rst) begin
      m_init = 1; m_run = 0; m_stop = 0; m_k = 0;
      m_per = 80; m_off = 20; m_cyc = 0;
    end else if (!m_run) begin
      if (bus.CFG_VALID) begin
        if (int'(bus.CFG_PERIOD) >= 2 &&
            bus.CFG_OFFSET < bus.CFG_PERIOD) begin
          m_per = int'(bus.CFG_PERIOD);
          m_off = int'(bus.CFG_OFFSET);
          m_cyc = int'(bus.CFG_CYCLES);
        end else begin
          e_err = 1;
        end
      end
      if (bus.START && !bus.ABORT) begin
        m_run = 1; m_stop = 0; m_k = 0;
      end
    end else begin
      last = (m_k % m_per) == (m_per - 1);
      if (last && ((m_cyc != 0 && m_k / m_per + 1 == m_cyc) || m_stop))
        end_run();
      else if (bus.ABORT && !m_stop) begin
`ifdef QSCHED_IMMEDIATE_ABORT_EN
        end_run();
`else
        m_stop = 1;
        m_k++;
`endif
      end else
        m_k++;
    end
  end

  always @(negedge clk) begin
    int es, ec;
    if (m_init) begin
      es = m_run ? m_k % m_per : 0;
      ec = m_run ? (m_off + m_k) % m_per : m_off;
      tests++;
      if (bus.SIN_ADDR !== 8'(es) || bus.COS_ADDR !== 8'(ec) ||
          bus.ADDR_VALID !== m_run || bus.BUSY !== m_run ||
          bus.PERIOD_START !== (m_run && es == 0) ||
          bus.DONE !== e_done || bus.CFG_ERR !== e_err ||
          bus.CFG_READY !== !m_run) begin
        fails++;
        $display("FAIL model t=%0t sin=%0d/%0d cos=%0d/%0d vld=%b/%b ps=%b done=%b/%b err=%b/%b rdy=%b",
                 $time, bus.SIN_ADDR, es, bus.COS_ADDR, ec,
                 bus.ADDR_VALID, m_run, bus.PERIOD_START,
                 bus.DONE, e_done, bus.CFG_ERR, e_err, bus.CFG_READY);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cfg(input int p, input int o, input int c);
    bus.CFG_VALID  = 1'b1;
    bus.CFG_PERIOD = 8'(p);
    bus.CFG_OFFSET = 8'(o);
    bus.CFG_CYCLES = 16'(c);
    step();
    bus.CFG_VALID = 1'b0;
  endtask

  task automatic go();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
  endtask

  task automatic stop();
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
  endtask

  task automatic wait_sin(input int v, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (bus.ADDR_VALID && int'(bus.SIN_ADDR) == v) return;
      step();
    end
    tests++; fails++;
    $display("FAIL wait_sin timeout got %0d want %0d", bus.SIN_ADDR, v);
  endtask

  task automatic wait_done(input int bound, output int n,
                           output int ls, output int lc);
    n = 0; ls = -1; lc = -1;
    for (int i = 0; i < bound; i++) begin
      if (bus.DONE) return;
      if (bus.ADDR_VALID) begin
        n++;
        ls = int'(bus.SIN_ADDR);
        lc = int'(bus.COS_ADDR);
      end
      step();
    end
    tests++; fails++;
    $display("FAIL wait_done timeout got %0d want 1", bus.DONE);
  endtask

  initial begin
    int n, ls, lc;
    bus.CFG_VALID = 0; bus.CFG_PERIOD = 0; bus.CFG_OFFSET = 0;
    bus.CFG_CYCLES = 0; bus.START = 0; bus.ABORT = 0;
    repeat (3) step();
    chk("rst_sin", bus.SIN_ADDR, 0);
    chk("rst_cos", bus.COS_ADDR, 20);
    chk("rst_rdy", bus.CFG_READY, 1);
    chk("rst_vld", bus.ADDR_VALID, 0);
    rst = 0;
    step();

    // default continuous run, then graceful/immediate abort
    go();
    chk("c_vld", bus.ADDR_VALID, 1);
    chk("c_sin0", bus.SIN_ADDR, 0);
    chk("c_cos0", bus.COS_ADDR, 20);
    chk("c_ps0", bus.PERIOD_START, 1);
    repeat (60) step();
    chk("c_sin60", bus.SIN_ADDR, 60);
    chk("c_cos60", bus.COS_ADDR, 0);
    repeat (20) step();
    chk("c_sin80", bus.SIN_ADDR, 0);
    chk("c_ps80", bus.PERIOD_START, 1);
    stop();
    wait_done(300, n, ls, lc);
`ifdef QSCHED_IMMEDIATE_ABORT_EN
    chk("c_abort_n", n, 0);
`else
    chk("c_abort_n", n, 79);
    chk("c_abort_ls", ls, 79);
`endif
    chk("c_done_cos", bus.COS_ADDR, 20);
    chk("c_done_vld", bus.ADDR_VALID, 0);

    // two periods of ten
    cfg(10, 3, 2);
    chk("p10_err", bus.CFG_ERR, 0);
    chk("p10_cos", bus.COS_ADDR, 3);
    go();
    wait_done(100, n, ls, lc);
    chk("p10_n", n, 20);
    chk("p10_ls", ls, 9);
    chk("p10_lc", lc, 2);
    chk("p10_dcos", bus.COS_ADDR, 3);

    // rejected configs keep the old one
    cfg(1, 0, 1);
    chk("bad1_err", bus.CFG_ERR, 1);
    step();
    chk("bad1_clr", bus.CFG_ERR, 0);
    cfg(10, 10, 1);
    chk("bad2_err", bus.CFG_ERR, 1);
    chk("bad2_cos", bus.COS_ADDR, 3);
    go();
    wait_done(100, n, ls, lc);
    chk("bad_n", n, 20);

    // abort at SIN=4
    go();
    wait_sin(4, 50);
    stop();
    wait_done(100, n, ls, lc);
`ifdef QSCHED_IMMEDIATE_ABORT_EN
    chk("ab4_n", n, 0);
`else
    chk("ab4_n", n, 5);
    chk("ab4_ls", ls, 9);
`endif

    // START with ABORT in IDLE
    bus.START = 1; bus.ABORT = 1;
    step();
    bus.START = 0; bus.ABORT = 0;
    chk("sa_busy", bus.BUSY, 0);
    step();
    chk("sa_vld", bus.ADDR_VALID, 0);

    // config offered while running is ignored
    cfg(10, 3, 0);
    go();
    repeat (3) step();
    bus.CFG_VALID = 1; bus.CFG_PERIOD = 20;
    bus.CFG_OFFSET = 5; bus.CFG_CYCLES = 1;
    chk("run_rdy", bus.CFG_READY, 0);
    step();
    bus.CFG_VALID = 0;
    chk("run_err", bus.CFG_ERR, 0);
    stop();
    wait_done(100, n, ls, lc);
    chk("run_cos", bus.COS_ADDR, 3);

    // single period, then back-to-back START in the DONE cycle
    cfg(10, 3, 1);
    go();
    wait_done(100, n, ls, lc);
    chk("one_n", n, 10);
    go();
    chk("b2b_vld", bus.ADDR_VALID, 1);
    chk("b2b_ps", bus.PERIOD_START, 1);
    wait_done(100, n, ls, lc);
    chk("b2b_n", n, 10);

    // reset mid-run restores defaults
    rst = 1; step(); rst = 0;
    go();
    wait_sin(37, 100);
    rst = 1;
    step();
    chk("mr_sin", bus.SIN_ADDR, 0);
    chk("mr_cos", bus.COS_ADDR, 20);
    chk("mr_vld", bus.ADDR_VALID, 0);
    chk("mr_done", bus.DONE, 0);
    rst = 0;
    step();

    for (int i = 0; i < 4000; i++) begin
      bus.CFG_VALID  = ($urandom_range(0, 7) == 0);
      bus.CFG_PERIOD = 8'($urandom_range(0, 15));
      bus.CFG_OFFSET = 8'($urandom_range(0, 15));
      bus.CFG_CYCLES = 16'($urandom_range(0, 3));
      bus.START      = ($urandom_range(0, 9) == 0);
      bus.ABORT      = ($urandom_range(0, 29) == 0);
      rst            = ($urandom_range(0, 499) == 0);
      step();
    end
    bus.CFG_VALID = 0; bus.START = 0; bus.ABORT = 0; rst = 0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_sweep_sched.md
# quad_sweep_sched

Scheduler for the quadrature sine/cosine lookup-address generator feeding the DDS/reference path. It takes a run configuration from the host command path: period, cosine phase offset, and number of periods. It validates and latches that configuration, then on START emits a phase-coherent stream of SIN/COS table addresses for the requested number of whole periods. It marks each period boundary for ADC capture alignment and reports completion. It replaces free-running address generation so that runs start and stop on period boundaries under host control.

## Interface
Parameters:
- ADDR_W, 8, width of period, offset and address fields
- CYC_W, 16, width of period-count field
- DEF_PERIOD, 80, period loaded at reset (table length)
- DEF_OFFSET, 20, cosine offset loaded at reset (quarter period)

Ports:
- CLK  in  1  single clock; everything is on the rising edge
- RST  in  1  synchronous, active-high reset
- CFG_VALID  in  1  configuration offer
- CFG_READY  out  1  high only in IDLE
- CFG_PERIOD  in  ADDR_W  samples per period
- CFG_OFFSET  in  ADDR_W  cosine start address
- CFG_CYCLES  in  CYC_W  periods per run; 0 means continuous
- START  in  1  one-cycle run request
- ABORT  in  1  one-cycle stop request
- SIN_ADDR  out  ADDR_W  sine table address
- COS_ADDR  out  ADDR_W  cosine table address
- ADDR_VALID  out  1  addresses are live
- PERIOD_START  out  1  high while SIN_ADDR==0 during RUN/STOP
- BUSY  out  1  state is RUN or STOP
- DONE  out  1  one-cycle pulse when a run ends
- CFG_ERR  out  1  one-cycle pulse when a configuration is rejected

## Operation
- States: IDLE, RUN, STOP.
- Reset values:
  - state IDLE
  - period DEF_PERIOD, offset DEF_OFFSET, cycles 0
  - SIN_ADDR 0, COS_ADDR DEF_OFFSET
  - ADDR_VALID, PERIOD_START, BUSY, DONE, CFG_ERR all 0; CFG_READY 1
- Config handshake:
  - Transfer when CFG_VALID && CFG_READY.
  - Accepted only if CFG_PERIOD ≥ 2 and CFG_OFFSET < CFG_PERIOD. Otherwise the latched config is unchanged and CFG_ERR pulses the next cycle.
  - CFG_VALID outside IDLE is not acknowledged.
- IDLE:
  - SIN_ADDR holds 0 and COS_ADDR holds the latched offset.
  - START moves to RUN and resets the period counter to 0.
  - START in the same cycle as an accepted config runs with the new config.
  - START together with ABORT: ABORT wins and the state stays IDLE.
- RUN:
  - SIN_ADDR increments and wraps from period-1 to 0.
  - COS_ADDR increments independently and wraps from period-1 to 0.
  - The period counter increments on each SIN wrap. When it reaches CFG_CYCLES (non-zero), the state returns to IDLE at that wrap edge and DONE pulses.
  - START is ignored.
- ABORT in RUN moves to STOP. STOP continues addressing until the SIN wrap, then returns to IDLE with a DONE pulse. ABORT in STOP or IDLE is ignored.
- Arithmetic:
  - Address compare is against period-1 at ADDR_W bits.
  - The period counter is CYC_W bits. Continuous mode never compares it, and it may wrap silently.
- RST mid-run: the next cycle shows the full reset state, with no DONE pulse and the latched config restored to defaults.

## Timing
- All outputs are registered.
- START sampled at edge t: from t+1, ADDR_VALID=1, BUSY=1, SIN_ADDR=0, COS_ADDR=offset, PERIOD_START=1.
- Run end: the last valid cycle shows SIN_ADDR=period-1. The following cycle shows ADDR_VALID=0, BUSY=0, DONE=1, SIN_ADDR=0, COS_ADDR=offset.
- A run of N periods gives exactly N·period ADDR_VALID cycles.
- CFG_ERR is raised one cycle after the offending handshake.
- Back-to-back: a START in the DONE cycle is accepted, so the minimum gap between runs is 1 cycle.

## Configuration
- QSCHED_IMMEDIATE_ABORT_EN:
  - Defined: ABORT in RUN returns to IDLE at the next edge with a DONE pulse. STOP is unreachable and may be optimised away.
  - Undefined (default): graceful abort through STOP, so the last period is always complete.

## Structure
- Package quad_sweep_pkg holds:
  - the state enum (IDLE/RUN/STOP)
  - DEF_PERIOD/DEF_OFFSET constants
  - the config struct {period, offset, cycles}
- Sub-module wrap_counter (load value, enable, limit, wrap flag) is instantiated twice, for SIN and COS.
- The scheduler FSM, config validation and period counter stay in the top level.

## Test plan
- Reset then START, default config, CFG_CYCLES=0 → SIN runs 0..79 and COS runs 20..79,0..19. PERIOD_START is high every 80 cycles, continuous until ABORT.
- Config period=10, offset=3, cycles=2, then START → exactly 20 ADDR_VALID cycles, DONE one cycle after SIN=9 on the second period, COS ends at 2.
- Config period=1, or offset=10 with period=10 → CFG_ERR pulse and old config retained. A subsequent run uses the previous period.
- ABORT at SIN_ADDR=4 with period=10 → addresses continue to 9, then DONE. With QSCHED_IMMEDIATE_ABORT_EN, DONE appears the next cycle.
- START and ABORT in the same IDLE cycle → no run. CFG_VALID during RUN → CFG_READY=0 and config unchanged.
- RST asserted mid-run at SIN_ADDR=37 → next cycle shows SIN=0, COS=20, ADDR_VALID=0, DONE=0.
